// File: rtl/beam_event_arbiter_if.sv
// Beam-event handshake bundle: pulse/enable/ack/clear toward the arbiter and
// interrupt, column and overflow back toward the processor side.
interface beam_event_arbiter_if #(
   parameter int NUM_BEAMS = 7,
   parameter int COL_W     = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1
);
   logic [NUM_BEAMS-1:0] beam_pulse;
   logic                 enable;
   logic                 event_ack;
   logic                 clear_ovf;
   logic                 FABINT;
   logic [COL_W-1:0]     event_col;
   logic                 event_valid;
   logic                 overflow;

   modport master (output beam_pulse, enable, event_ack, clear_ovf,
                   input  FABINT, event_col, event_valid, overflow);
   modport slave  (input  beam_pulse, enable, event_ack, clear_ovf,
                   output FABINT, event_col, event_valid, overflow);
endinterface

// File: rtl/beam_event_arbiter.sv
// Per-column break-beam lockout and latching, round-robin arbitration, and a
// FABINT/ack handshake that re-pulses the interrupt when the ack is late.
module beam_event_arbiter #(
   parameter int NUM_BEAMS      = 7,
   parameter int LOCKOUT_CYCLES = 100000000,
   parameter int ACK_TIMEOUT    = 1000000,
   parameter int COL_W          = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1
) (
   input logic                 clk,
   input logic                 rst,
   beam_event_arbiter_if.slave bus
);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]           r_state;
   logic [NUM_BEAMS-1:0] r_pend;
   logic [COL_W-1:0]     r_rr;
   logic [COL_W-1:0]     r_col;
   logic [TW-1:0]        r_tmo;
   logic                 r_ovf;
   logic [LW-1:0]        r_lock [NUM_BEAMS];

   logic [NUM_BEAMS-1:0] w_acc;
   logic [NUM_BEAMS-1:0] w_clr;
   logic [NUM_BEAMS-1:0] w_ovf_hit;
   logic [COL_W-1:0]     w_win;
   logic [COL_W:0]       w_sum;
   logic                 w_ack;

   // Ack only counts while an event is actually outstanding.
   assign w_ack = (r_state == S_WAIT) && bus.event_ack;

   generate
      for (genvar g = 0; g < NUM_BEAMS; g++) begin : g_lane
         assign w_acc[g]     = bus.enable && bus.beam_pulse[g] && (r_lock[g] == '0);
         assign w_clr[g]     = w_ack && (r_col == COL_W'(g));
         // A pulse landing on the column being acked re-arms it rather than overflowing.
         assign w_ovf_hit[g] = w_acc[g] && r_pend[g] && !w_clr[g];

         always_ff @(posedge clk or posedge rst) begin
            if (rst)                 r_lock[g] <= '0;
            else if (!bus.enable)    r_lock[g] <= '0;
            else if (w_acc[g])       r_lock[g] <= LW'(LOCKOUT_CYCLES);
            else if (r_lock[g] != '0) r_lock[g] <= r_lock[g] - 1'b1;
         end
      end
   endgenerate

   // Scan downward so the nearest pending column at or after r_rr is the last write.
   always_comb begin
      w_win = '0;
      w_sum = '0;
      for (int k = NUM_BEAMS - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr} + (COL_W + 1)'(k);
         if (w_sum >= (COL_W + 1)'(NUM_BEAMS))
            w_sum = w_sum - (COL_W + 1)'(NUM_BEAMS);
         if (r_pend[w_sum[COL_W-1:0]])
            w_win = w_sum[COL_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_rr    <= '0;
         r_col   <= '0;
         r_tmo   <= '0;
      end else if (!bus.enable) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_tmo   <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_acc;
         case (r_state)
            S_IDLE: begin
               if (|r_pend) begin
                  r_col   <= w_win;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_tmo   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.event_ack) begin
                  r_rr    <= (r_col == COL_W'(NUM_BEAMS - 1)) ? '0 : r_col + 1'b1;
                  r_state <= S_IDLE;
               end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                  r_state <= S_ISSUE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Sticky overflow survives a flush; a same-cycle set beats clear_ovf.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_ovf <= 1'b0;
      else if (|w_ovf_hit)    r_ovf <= 1'b1;
      else if (bus.clear_ovf) r_ovf <= 1'b0;
   end

   assign bus.FABINT      = (r_state == S_ISSUE);
   assign bus.event_valid = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign bus.event_col   = r_col;
   assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_beam_event_arbiter.sv
// Directed scenarios plus a randomized run compared against an event-level
// model of the beam arbiter (timestamped lockouts, modular round-robin search).
module tb_beam_event_arbiter;
   localparam int NB   = 7;
   localparam int LOCK = 20;
   localparam int TO   = 50;
   localparam int CW   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic man_ack  = 1'b0;
   logic auto_ack = 1'b0;
   logic auto_q   = 1'b0;

   beam_event_arbiter_if #(.NUM_BEAMS(NB)) bus ();

   beam_event_arbiter #(
      .NUM_BEAMS(NB), .LOCKOUT_CYCLES(LOCK), .ACK_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.event_ack = man_ack | auto_q;

   // Auto-ack answers one cycle after FABINT, i.e. in the first WAIT_ACK cycle.
   always @(negedge clk) auto_q = auto_ack && bus.event_valid && !bus.FABINT;

   int            cyc = 0;
   int            fab_cnt = 0;
   int            fab_t[$];
   logic [CW-1:0] fab_c[$];

   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (bus.FABINT === 1'b1) begin
         fab_cnt++;
         fab_t.push_back(cyc);
         fab_c.push_back(bus.event_col);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   bit m_pend [NB];
   int m_last [NB];
   int m_t, m_phase, m_col, m_rr, m_wait;
   bit m_ovf;

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_pend[i] = 1'b0;
         m_last[i] = -1000;
      end
      m_t = 0; m_phase = 0; m_col = 0; m_rr = 0; m_wait = 0; m_ovf = 1'b0;
   endtask

   task automatic model_update();
      bit old_pend [NB];
      bit acc, set_ovf;
      int served;
      m_t++;
      served = (m_phase == 2 && bus.event_ack) ? m_col : -1;
      if (!bus.enable) begin
         for (int i = 0; i < NB; i++) begin
            m_pend[i] = 1'b0;
            m_last[i] = -1000;
         end
         m_phase = 0;
         m_wait  = 0;
         if (bus.clear_ovf) m_ovf = 1'b0;
         return;
      end
      old_pend = m_pend;
      set_ovf  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         acc = bus.beam_pulse[i] && (m_t - m_last[i] > LOCK);
         if (acc && old_pend[i] && i != served) set_ovf = 1'b1;
         m_pend[i] = (old_pend[i] && i != served) || acc;
         if (acc) m_last[i] = m_t;
      end
      if (set_ovf) m_ovf = 1'b1;
      else if (bus.clear_ovf) m_ovf = 1'b0;
      case (m_phase)
         0: begin
            for (int k = NB - 1; k >= 0; k--)
               if (old_pend[(m_rr + k) % NB]) begin
                  m_col   = (m_rr + k) % NB;
                  m_phase = 1;
               end
         end
         1: begin
            m_phase = 2;
            m_wait  = 0;
         end
         default: begin
            if (served >= 0) begin
               m_rr    = (m_col + 1) % NB;
               m_phase = 0;
            end else begin
               m_wait++;
               if (m_wait == TO) m_phase = 1;
            end
         end
      endcase
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [NB-1:0] m);
      bus.beam_pulse = m;
      tick();
      bus.beam_pulse = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.beam_pulse = '0;
      bus.enable     = 1'b1;
      bus.clear_ovf  = 1'b0;
      man_ack  = 1'b0;
      auto_ack = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_fab(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (bus.FABINT === 1'b1) got = 1'b1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.enable = 1'b1;
      bus.beam_pulse = '1;
      bus.clear_ovf = 1'b0;
      repeat (3) tick();
      checks++; if (bus.FABINT !== 1'b0) begin errors++; $display("FAIL reset_fabint: got %b expected 0", bus.FABINT); end
      checks++; if (bus.event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.event_valid); end
      checks++; if (bus.event_col !== 3'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", bus.event_col); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
      bus.beam_pulse = '0;
   endtask

   task automatic test_single();
      int n0;
      do_reset();
      n0 = fab_cnt;
      pulse(7'b0001000);
      checks++; if (bus.FABINT !== 1'b0 || bus.event_valid !== 1'b0) begin errors++; $display("FAIL single_early: fabint %b valid %b expected 0 0", bus.FABINT, bus.event_valid); end
      tick();
      checks++; if (bus.FABINT !== 1'b1) begin errors++; $display("FAIL single_latency: fabint %b expected 1", bus.FABINT); end
      checks++; if (bus.event_col !== 3'd3) begin errors++; $display("FAIL single_col: got %0d expected 3", bus.event_col); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.event_valid !== 1'b1 || bus.FABINT !== 1'b0) begin errors++; $display("FAIL single_hold: valid %b fabint %b expected 1 0", bus.event_valid, bus.FABINT); end
      end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      checks++; if (bus.event_valid !== 1'b0) begin errors++; $display("FAIL single_drop: valid %b expected 0", bus.event_valid); end
      repeat (10) tick();
      checks++; if (fab_cnt - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d FABINTs expected 1", fab_cnt - n0); end
   endtask

   task automatic test_lockout();
      int n0;
      do_reset();
      auto_ack = 1'b1;
      n0 = fab_cnt;
      pulse(7'b0000100);
      repeat (9) tick();
      pulse(7'b0000100);
      repeat (14) tick();
      checks++; if (fab_cnt - n0 !== 1) begin errors++; $display("FAIL lockout_ignored: got %0d FABINTs expected 1", fab_cnt - n0); end
      pulse(7'b0000100);
      repeat (10) tick();
      checks++; if (fab_cnt - n0 !== 2) begin errors++; $display("FAIL lockout_expired: got %0d FABINTs expected 2", fab_cnt - n0); end
      else begin
         checks++; if (fab_c[n0+1] !== 3'd2) begin errors++; $display("FAIL lockout_col: got %0d expected 2", fab_c[n0+1]); end
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_simultaneous();
      int n0, n1;
      logic [CW-1:0] exp1 [3];
      exp1[0] = 3'd1; exp1[1] = 3'd4; exp1[2] = 3'd6;
      do_reset();
      auto_ack = 1'b1;
      n0 = fab_cnt;
      pulse(7'b1010010);
      repeat (15) tick();
      checks++; if (fab_cnt - n0 !== 3) begin errors++; $display("FAIL simul_count: got %0d expected 3", fab_cnt - n0); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (fab_c[n0+i] !== exp1[i]) begin errors++; $display("FAIL simul_order%0d: got %0d expected %0d", i, fab_c[n0+i], exp1[i]); end
         end
         checks++; if (fab_t[n0+1] - fab_t[n0] !== 3) begin errors++; $display("FAIL simul_spacing: got %0d expected 3", fab_t[n0+1] - fab_t[n0]); end
      end
      // Serving 6 wraps the pointer to 0, so column 0 is found before 5.
      n1 = fab_cnt;
      pulse(7'b0100001);
      repeat (12) tick();
      checks++; if (fab_cnt - n1 !== 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", fab_cnt - n1); end
      else begin
         checks++; if (fab_c[n1] !== 3'd0 || fab_c[n1+1] !== 3'd5) begin errors++; $display("FAIL wrap_order: got %0d,%0d expected 0,5", fab_c[n1], fab_c[n1+1]); end
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_timeout();
      int n0, n1;
      bit got;
      do_reset();
      pulse(7'b0000001);
      n0 = fab_cnt;
      wait_fab(5, got);
      checks++; if (!got) begin errors++; $display("FAIL timeout_first: no FABINT within 5 cycles"); end
      repeat (103) tick();
      checks++; if (fab_cnt - n0 !== 3) begin errors++; $display("FAIL timeout_count: got %0d expected 3", fab_cnt - n0); end
      else begin
         for (int i = 1; i < 3; i++) begin
            checks++; if (fab_t[n0+i] - fab_t[n0+i-1] !== 51) begin errors++; $display("FAIL timeout_period%0d: got %0d expected 51", i, fab_t[n0+i] - fab_t[n0+i-1]); end
            checks++; if (fab_c[n0+i] !== 3'd0) begin errors++; $display("FAIL timeout_col%0d: got %0d expected 0", i, fab_c[n0+i]); end
         end
      end
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      checks++; if (bus.event_valid !== 1'b0) begin errors++; $display("FAIL timeout_ack: valid %b expected 0", bus.event_valid); end
      n1 = fab_cnt;
      repeat (120) tick();
      checks++; if (fab_cnt - n1 !== 0) begin errors++; $display("FAIL timeout_stop: got %0d FABINTs expected 0", fab_cnt - n1); end
   endtask

   task automatic test_overflow();
      do_reset();
      pulse(7'b0100000);
      repeat (20) tick();
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", bus.overflow); end
      pulse(7'b0100000);
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
      bus.clear_ovf = 1'b1;
      tick();
      bus.clear_ovf = 1'b0;
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
      repeat (19) tick();
      bus.clear_ovf = 1'b1;
      pulse(7'b0100000);
      bus.clear_ovf = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow); end
      bus.enable = 1'b0;
      tick();
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flush_hold: got %b expected 1", bus.overflow); end
      checks++; if (bus.event_valid !== 1'b0) begin errors++; $display("FAIL ovf_flush_valid: got %b expected 0", bus.event_valid); end
      bus.enable = 1'b1;
   endtask

   task automatic test_reset_flush();
      int n0;
      bit got;
      do_reset();
      pulse(7'b0000010);
      wait_fab(5, got);
      tick();
      checks++; if (!got || bus.event_valid !== 1'b1) begin errors++; $display("FAIL rst_setup: got %b valid %b expected 1 1", got, bus.event_valid); end
      rst = 1'b1;
      #1;
      checks++; if (bus.FABINT !== 1'b0 || bus.event_valid !== 1'b0) begin errors++; $display("FAIL rst_async: fabint %b valid %b expected 0 0", bus.FABINT, bus.event_valid); end
      checks++; if (bus.event_col !== 3'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_async_col: col %0d ovf %b expected 0 0", bus.event_col, bus.overflow); end
      tick();
      rst = 1'b0;
      tick();
      n0 = fab_cnt;
      pulse(7'b0011100);
      bus.enable = 1'b0;
      repeat (2) tick();
      bus.enable = 1'b1;
      repeat (40) tick();
      checks++; if (fab_cnt - n0 !== 0) begin errors++; $display("FAIL flush_fabint: got %0d FABINTs expected 0", fab_cnt - n0); end
      checks++; if (bus.event_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.event_valid); end
   endtask

   task automatic test_random();
      logic [NB-1:0] p;
      int ack_div;
      do_reset();
      model_reset();
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < NB; i++) p[i] = ($urandom_range(0, 9) == 0);
         ack_div = (n < 1000) ? 3 : 70;
         bus.beam_pulse = p;
         bus.enable     = ($urandom_range(0, 59) != 0);
         bus.clear_ovf  = ($urandom_range(0, 39) == 0);
         man_ack        = ($urandom_range(0, ack_div) == 0);
         @(negedge clk);
         #1;
         model_update();
         tick();
         checks++; if (bus.FABINT !== (m_phase == 1)) begin errors++; $display("FAIL rand_fabint@%0d: got %b expected %b", n, bus.FABINT, m_phase == 1); end
         checks++; if (bus.event_valid !== (m_phase != 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, bus.event_valid, m_phase != 0); end
         checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf@%0d: got %b expected %b", n, bus.overflow, m_ovf); end
         if (m_phase != 0) begin
            checks++; if (bus.event_col !== CW'(m_col)) begin errors++; $display("FAIL rand_col@%0d: got %0d expected %0d", n, bus.event_col, m_col); end
         end
      end
      bus.beam_pulse = '0;
      bus.clear_ovf  = 1'b0;
      bus.enable     = 1'b1;
      man_ack        = 1'b0;
   endtask

   initial begin
      bus.beam_pulse = '0;
      bus.enable     = 1'b0;
      bus.clear_ovf  = 1'b0;
      test_reset();
      test_single();
      test_lockout();
      test_simultaneous();
      test_timeout();
      test_overflow();
      test_reset_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
